asteroid_field: RTL and testbench



---
 rtl/asteroid_field.sv | 189 ++++++++++++++++++
 tb/tb_asteroid_field.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_field.sv
// Three-slot asteroid generator: each frame it moves every live slot down, retires slots that leave
// the screen and periodically spawns a new slot from an LFSR. Optional feature macro: ASTEROID_SPEEDUP_EN.
module asteroid_field #(
    parameter int unsigned SPAWN_INTERVAL = 60,
    parameter int unsigned SCREEN_H       = 480,
    parameter int unsigned X_OFFSET       = 32,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        frame_tick,
    output logic [29:0] xpos,
    output logic [29:0] ypos,
    output logic [2:0]  active,
    output logic        spawn_pulse,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, SPAWN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q [3];
    logic [9:0]  x_d [3];
    logic [9:0]  y_q [3];
    logic [9:0]  y_d [3];
    logic [2:0]  speed_q [3];
    logic [2:0]  speed_d [3];
    logic [2:0]  active_q, active_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        spawn_pulse_q, spawn_pulse_d;
    logic        busy_q, busy_d;

    logic        upd_en;
    logic [1:0]  upd_sel;
    logic [10:0] y_next;
    logic        free_found;
    logic [1:0]  free_idx;
    logic [2:0]  spawn_speed;

`ifdef ASTEROID_SPEEDUP_EN
    logic [3:0]  spawn_cnt_q, spawn_cnt_d;
    logic [2:0]  base_q, base_d;
`endif

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!halt) begin
            case (state_q)
                IDLE:    if (frame_tick) state_d = UPD0;
                UPD0:    state_d = UPD1;
                UPD1:    state_d = UPD2;
                UPD2:    state_d = SPAWN;
                SPAWN:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        speed_d       = speed_q;
        active_d      = active_q;
        cnt_d         = cnt_q;
        lfsr_d        = lfsr_q;
        spawn_pulse_d = spawn_pulse_q;
        busy_d        = busy_q;
`ifdef ASTEROID_SPEEDUP_EN
        spawn_cnt_d   = spawn_cnt_q;
        base_d        = base_q;
`endif

        upd_en  = 1'b0;
        upd_sel = 2'd0;
        case (state_q)
            UPD0:    begin upd_en = 1'b1; upd_sel = 2'd0; end
            UPD1:    begin upd_en = 1'b1; upd_sel = 2'd1; end
            UPD2:    begin upd_en = 1'b1; upd_sel = 2'd2; end
            default: begin upd_en = 1'b0; upd_sel = 2'd0; end
        endcase
        y_next = {1'b0, y_q[upd_sel]} + {8'd0, speed_q[upd_sel]};

        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!active_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end

`ifdef ASTEROID_SPEEDUP_EN
        spawn_speed = 3'd1 + {1'b0, lfsr_q[10:9]} + base_q;
`else
        spawn_speed = 3'd1 + {1'b0, lfsr_q[10:9]};
`endif

        // halt freezes every register, outputs included
        if (!halt) begin
            busy_d        = (state_d != IDLE);
            spawn_pulse_d = 1'b0;

            if (state_q == IDLE && frame_tick) begin
                lfsr_d = lfsr_step(lfsr_q);
            end

            if (upd_en && active_q[upd_sel]) begin
                if (y_next >= 11'(SCREEN_H)) begin
                    active_d[upd_sel] = 1'b0;
                    y_d[upd_sel]      = '0;
                end else begin
                    y_d[upd_sel] = y_next[9:0];
                end
            end

            if (state_q == SPAWN) begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (free_found) begin
                    active_d[free_idx] = 1'b1;
                    y_d[free_idx]      = '0;
                    x_d[free_idx]      = {1'b0, lfsr_q[8:0]} + 10'(X_OFFSET);
                    speed_d[free_idx]  = spawn_speed;
                    cnt_d              = 8'(SPAWN_INTERVAL - 1);
                    spawn_pulse_d      = 1'b1;
`ifdef ASTEROID_SPEEDUP_EN
                    spawn_cnt_d = spawn_cnt_q + 4'd1;
                    if (spawn_cnt_q == 4'hF && base_q != 3'd3) begin
                        base_d = base_q + 3'd1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                speed_q[i] <= '0;
            end
            active_q      <= '0;
            cnt_q         <= 8'(SPAWN_INTERVAL - 1);
            lfsr_q        <= LFSR_SEED;
            spawn_pulse_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ASTEROID_SPEEDUP_EN
            spawn_cnt_q   <= '0;
            base_q        <= '0;
`endif
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            speed_q       <= speed_d;
            active_q      <= active_d;
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
            spawn_pulse_q <= spawn_pulse_d;
            busy_q        <= busy_d;
`ifdef ASTEROID_SPEEDUP_EN
            spawn_cnt_q   <= spawn_cnt_d;
            base_q        <= base_d;
`endif
        end
    end

    assign xpos        = {x_q[2], x_q[1], x_q[0]};
    assign ypos        = {y_q[2], y_q[1], y_q[0]};
    assign active      = active_q;
    assign spawn_pulse = spawn_pulse_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_asteroid_field.sv
// Directed bench for asteroid_field with a short spawn interval and a small screen height
// so that spawning, full-slot retry and the retire boundary all occur within a few frames.
module tb_asteroid_field;

    localparam int unsigned SI   = 2;
    localparam int unsigned SH   = 13;
    localparam int unsigned XO   = 32;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        frame_tick;
    logic [29:0] xpos;
    logic [29:0] ypos;
    logic [2:0]  active;
    logic        spawn_pulse;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int mx [3];
    int my [3];
    int ms [3];
    bit ma [3];
    int ox [3];
    int oy [3];
    bit oa [3];
    int hx [3];
    int hy [3];
    bit ha [3];
    int          mcnt;
    logic [15:0] mlfsr;
    bit          mspawn;

    logic        post_upd0_a0;
    logic [9:0]  post_upd0_y0;

    asteroid_field #(
        .SPAWN_INTERVAL(SI),
        .SCREEN_H(SH),
        .X_OFFSET(XO),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .halt(halt),
        .frame_tick(frame_tick),
        .xpos(xpos),
        .ypos(ypos),
        .active(active),
        .spawn_pulse(spawn_pulse),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            mx[n] = 0; my[n] = 0; ms[n] = 0; ma[n] = 1'b0;
        end
        mcnt  = SI - 1;
        mlfsr = SEED;
    endtask

    task automatic model_frame();
        logic [15:0] l;
        for (int n = 0; n < 3; n++) begin
            ox[n] = mx[n]; oy[n] = my[n]; oa[n] = ma[n];
        end
        mlfsr = lfsr_next(mlfsr);
        for (int n = 0; n < 3; n++) begin
            if (ma[n]) begin
                if (my[n] + ms[n] >= SH) begin
                    ma[n] = 1'b0;
                    my[n] = 0;
                end else begin
                    my[n] = my[n] + ms[n];
                end
            end
            hx[n] = mx[n]; hy[n] = my[n]; ha[n] = ma[n];
        end
        mspawn = 1'b0;
        l = mlfsr;
        if (mcnt != 0) begin
            mcnt--;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (!ma[n] && !mspawn) begin
                    ma[n]  = 1'b1;
                    my[n]  = 0;
                    mx[n]  = int'(l[8:0]) + XO;
                    ms[n]  = 1 + int'(l[10:9]);
                    mcnt   = SI - 1;
                    mspawn = 1'b1;
                end
            end
        end
    endtask

    // stage 0..3: slots below 'stage' show post-update values, the rest pre-frame; stage 4: final
    task automatic check_buses(input string tag, input int stage);
        logic [29:0] ex, ey;
        logic [2:0]  ea;
        for (int n = 0; n < 3; n++) begin
            if (stage == 4) begin
                ex[n*10 +: 10] = 10'(mx[n]); ey[n*10 +: 10] = 10'(my[n]); ea[n] = ma[n];
            end else if (n < stage) begin
                ex[n*10 +: 10] = 10'(hx[n]); ey[n*10 +: 10] = 10'(hy[n]); ea[n] = ha[n];
            end else begin
                ex[n*10 +: 10] = 10'(ox[n]); ey[n*10 +: 10] = 10'(oy[n]); ea[n] = oa[n];
            end
        end
        check({tag, "_xpos"}, 32'(xpos), 32'(ex));
        check({tag, "_ypos"}, 32'(ypos), 32'(ey));
        check({tag, "_active"}, 32'(active), 32'(ea));
    endtask

    task automatic run_frame(input bit extra_tick);
        int c;
        model_frame();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = extra_tick;
        c = 0;
        while (busy && c < 8) begin
            check_buses($sformatf("stage%0d", c), c);
            if (c == 1) begin
                post_upd0_a0 = active[0];
                post_upd0_y0 = ypos[9:0];
            end
            c++;
            @(posedge clk); #1;
            frame_tick = 1'b0;
        end
        check("busy_len", 32'(c), 32'd4);
        check_buses("final", 4);
        check("spawn_pulse", 32'(spawn_pulse), 32'(mspawn));
        @(posedge clk); #1;
        check("pulse_clear", 32'(spawn_pulse), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_xpos"}, 32'(xpos), 32'd0);
        check({tag, "_ypos"}, 32'(ypos), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pulse"}, 32'(spawn_pulse), 32'd0);
        check({tag, "_lfsr"}, 32'(dut.lfsr_q), 32'h0000ACE1);
        check({tag, "_cnt"}, 32'(dut.cnt_q), 32'd1);
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; frame_tick = 1'b0;
        post_upd0_a0 = 1'b1; post_upd0_y0 = '1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        model_reset();

        // frame 1: countdown only
        run_frame(1'b0);
        check("f1_active", 32'(active), 32'd0);
        check("f1_cnt", 32'(dut.cnt_q), 32'd0);

        // frame 2: lfsr 0x7138 -> x = 312 + 32, speed 1
        run_frame(1'b0);
        check("f2_active", 32'(active), 32'b001);
        check("f2_x0", 32'(xpos[9:0]), 32'd344);
        check("f2_y0", 32'(ypos[9:0]), 32'd0);

        // frames 3..8: slots 1 and 2 spawn, frame 8 finds no free slot
        repeat (6) run_frame(1'b0);
        check("f8_active", 32'(active), 32'b111);
        check("f8_cnt", 32'(dut.cnt_q), 32'd0);
        check("f8_y1", 32'(ypos[19:10]), 32'd12);

        // frame 9: slot 1 (y 12, speed 3) retires and respawns from lfsr 0x6162
        run_frame(1'b0);
        check("f9_active", 32'(active), 32'b111);
        check("f9_x1", 32'(xpos[19:10]), 32'd386);
        check("f9_y1", 32'(ypos[19:10]), 32'd0);

        repeat (4) run_frame(1'b0);
        // frame 14: slot 0 at y = SCREEN_H-1 is still live
        run_frame(1'b0);
        check("f14_a0", 32'(active[0]), 32'd1);
        check("f14_y0", 32'(ypos[9:0]), 32'd12);
        // frame 15: y + speed = SCREEN_H retires during UPD0
        run_frame(1'b0);
        check("f15_retire_a0", 32'(post_upd0_a0), 32'd0);
        check("f15_retire_y0", 32'(post_upd0_y0), 32'd0);

        // frame_tick held into UPD0 must not start another frame
        run_frame(1'b1);

        // halt: ten ticks dropped, nothing moves
        @(negedge clk);
        halt = 1'b1;
        repeat (10) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            check("halt_busy", 32'(busy), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        check_buses("halt", 4);
        check("halt_lfsr", 32'(dut.lfsr_q), 32'(mlfsr));
        check("halt_cnt", 32'(dut.cnt_q), 32'(mcnt));
        @(negedge clk);
        halt = 1'b0;
        run_frame(1'b0);

        // reset asserted while in UPD1
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midreset");
        reset = 1'b0;
        model_reset();

        run_frame(1'b0);
        check("post_lfsr", 32'(dut.lfsr_q), 32'h0000E270);
        check("post_cnt", 32'(dut.cnt_q), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
